st_stack_ctrl: RTL and testbench
================================

Name: st_stack_ctrl

Overview:
- Control end of the stack-operation datapath: accepts 16-bit Thumb stack instructions over a valid/ready handshake, owns the SP register, and drives op_sel/immed7/immed8 into the stack datapath, using its data_out as next SP or memory address.
- Sequences multi-register PUSH/POP as one memory word per transfer.
- Sits between the instruction fetch stage, the register file and the data-memory port.

Parameters:
SP_RESET, 32'h0000_1000, SP value after reset (bits [1:0] must be 00)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
instr_valid  in  1  instruction offered
instr  in  16  Thumb instruction
instr_ready  out  1  block can accept an instruction
op_sel  out  8  one-hot op to datapath: NOP 00, PUSH 01, POP 02, ADDSP 04, SUBSP 08, MOVSP 10, ADDS 20, LDRSP 40, STRSP 80
immed7  out  7  to datapath
immed8  out  8  to datapath
dp_in  out  32  datapath data_in
dp_out  in  32  datapath data_out (combinational from op_sel/dp_in/immediates)
sp_out  out  32  current SP
rf_raddr  out  4  register-file read address (combinational read)
rf_rdata  in  32  register-file read data
rf_we  out  1  register-file write strobe
rf_waddr  out  4  register-file write address
rf_wdata  out  32  register-file write data
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = write
mem_addr  out  32  word address
mem_wdata  out  32  write data
mem_ack  in  1  single-cycle completion
mem_rdata  in  32  read data, valid with mem_ack
done  out  1  one-cycle pulse, instruction retired
illegal  out  1  one-cycle pulse, instruction rejected

Behaviour:
- Reset values:
  - Outputs: SP = SP_RESET; state IDLE; op_sel = NOP; mem_req = rf_we = done = illegal = 0; instr_ready = 1.
  - Reset mid-operation aborts the instruction. mem_req is low from the next cycle, no done, partial SP updates discarded.
- Outputs outside states below: op_sel = NOP, dp_in = SP, immediates 0.
- States: IDLE, EXEC, MEM, PUSH, POP.
- IDLE:
  - instr_ready = 1.
  - On instr_valid: latch instr and decode.
    - ADD/SUB SP,#imm7 (1011_0000_s_imm7), ADD Rd,SP,#imm8 (10101_Rd_imm8), MOV SP,Rm (01000110_1_Rm_101) → EXEC.
    - LDR/STR Rd,[SP,#imm8] (10011/10010_Rd_imm8) → MEM.
    - PUSH {rlist,LR} (1011010R_rlist) → PUSH.
    - POP {rlist,PC} (1011110R_rlist) → POP.
    - Anything else, or PUSH/POP with empty list → illegal pulse next cycle, stay IDLE.
  - instr_ready = 0 in every other state; instr_valid is ignored there.
- EXEC (1 cycle, done high):
  - ADDSP/SUBSP: SP <= dp_out.
  - ADDS: rf_we, rf_waddr = Rd, rf_wdata = dp_out.
  - MOVSP: rf_raddr = Rm, dp_in = rf_rdata, SP <= {dp_out[31:2],2'b00}.
  - Return to IDLE.
  - Latency: accept edge N, done at N+1, instr_ready at N+2.
- MEM:
  - op_sel LDRSP/STRSP, dp_in = SP, mem_addr = dp_out, mem_req = 1.
  - STR: mem_we = 1, mem_wdata = rf_rdata(Rd).
  - On mem_ack: LDR writes rf[Rd] = mem_rdata same cycle; done; → IDLE. SP unchanged.
- PUSH (full-descending):
  - Pending set is rlist bits 0-7 plus r14 if R=1. Each transfer targets the highest pending register.
  - Per transfer: op_sel PUSH, dp_in = SP, mem_addr = dp_out, mem_we = 1, mem_wdata = rf_rdata(reg), mem_req = 1.
  - On ack: SP <= dp_out, clear the bit.
  - Result: lowest register at lowest address.
- POP:
  - Pending set is rlist bits 0-7 plus r15 if R=1. Each transfer targets the lowest pending register.
  - Per transfer: mem_addr = SP, mem_we = 0, op_sel POP, dp_in = SP, mem_req = 1.
  - On ack: rf write reg = mem_rdata, SP <= dp_out, clear the bit.
- PUSH/POP completion: done is asserted in the cycle of the final ack. mem_req drops the following cycle and state returns to IDLE.
- Memory handshake: mem_addr, mem_we, mem_wdata and op_sel stay stable while mem_req is high and mem_ack is low. mem_ack with mem_req low is ignored.
- Arithmetic is the datapath's: 32-bit modulo 2^32, so SP 0 − 4 = 0xFFFF_FFFC.

Test Plan:
- Reset, then SUB SP,#3 (0xB083) → done at accept+1; sp_out 0x0000_0FF4.
- With SP 0x1000, r1 = 0x11, r3 = 0x33, LR = 0xEE: PUSH {r1,r3,LR} (0xB50A), ack each request after 2 wait cycles → writes 0xEE@0xFFC, 0x33@0xFF8, 0x11@0xFF4; sp_out 0xFF4; one done.
- POP {r1,r3,PC} from SP 0xFF4 (0xBD0A) → reads 0xFF4, 0xFF8, 0xFFC into r1, r3, r15 in that order; SP 0x1000.
- LDR r2,[SP,#5] (0x9A05) with SP 0x1000, mem_rdata 0xDEAD_BEEF → mem_addr 0x1014; rf write r2 = 0xDEADBEEF; SP unchanged.
- MOV SP,r4 with r4 = 0x0000_2003 (0x46A5) → sp_out 0x2000. ADD r0,SP,#1 → r0 = 0x2004.
- SP 0x0, PUSH {r0} → mem_addr 0xFFFF_FFFC.
- Illegal 0xB400 → illegal pulse, no mem_req.
- reset asserted mid-PUSH while mem_req is high → mem_req 0 next cycle, sp_out = SP_RESET, no done.

Source files
------------

// File: rtl/st_stack_ctrl.sv
// Control FSM for the Thumb stack-operation datapath: owns SP, decodes stack
// instructions and sequences multi-register PUSH/POP one memory word at a time.
module st_stack_ctrl #(
    parameter logic [31:0] SP_RESET = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [7:0]  op_sel,
    output logic [6:0]  immed7,
    output logic [7:0]  immed8,
    output logic [31:0] dp_in,
    input  logic [31:0] dp_out,
    output logic [31:0] sp_out,
    output logic [3:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        done,
    output logic        illegal
);

    localparam logic [7:0] OpNop   = 8'h00;
    localparam logic [7:0] OpPush  = 8'h01;
    localparam logic [7:0] OpPop   = 8'h02;
    localparam logic [7:0] OpAddsp = 8'h04;
    localparam logic [7:0] OpSubsp = 8'h08;
    localparam logic [7:0] OpMovsp = 8'h10;
    localparam logic [7:0] OpAdds  = 8'h20;
    localparam logic [7:0] OpLdrsp = 8'h40;
    localparam logic [7:0] OpStrsp = 8'h80;

    typedef enum logic [2:0] {StIdle, StExec, StMem, StPush, StPop} state_e;

    state_e      state_q, state_d;
    logic [10:0] ir_q, ir_d;
    logic [7:0]  op_q, op_d;
    logic [15:0] list_q, list_d;
    logic [31:0] sp_q, sp_d;
    logic        illegal_q, illegal_d;

    logic [7:0]  dec_op;
    state_e      dec_state;
    logic [15:0] dec_list;
    logic [3:0]  hi_idx, lo_idx, cur_idx;
    logic        last_xfer;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            ir_q      <= '0;
            op_q      <= OpNop;
            list_q    <= '0;
            sp_q      <= SP_RESET;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            op_q      <= op_d;
            list_q    <= list_d;
            sp_q      <= sp_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        dec_op    = OpNop;
        dec_state = StIdle;
        dec_list  = '0;
        if (instr[15:8] == 8'hB0) begin
            dec_op    = instr[7] ? OpSubsp : OpAddsp;
            dec_state = StExec;
        end else if (instr[15:11] == 5'b10101) begin
            dec_op    = OpAdds;
            dec_state = StExec;
        end else if (instr[15:7] == 9'b0100_0110_1 && instr[2:0] == 3'b101) begin
            dec_op    = OpMovsp;
            dec_state = StExec;
        end else if (instr[15:11] == 5'b10011) begin
            dec_op    = OpLdrsp;
            dec_state = StMem;
        end else if (instr[15:11] == 5'b10010) begin
            dec_op    = OpStrsp;
            dec_state = StMem;
        end else if (instr[15:9] == 7'b1011010 && (instr[8] || (instr[7:0] != 8'h00))) begin
            dec_op    = OpPush;
            dec_state = StPush;
            dec_list  = {1'b0, instr[8], 6'b0, instr[7:0]};
        end else if (instr[15:9] == 7'b1011110 && (instr[8] || (instr[7:0] != 8'h00))) begin
            dec_op    = OpPop;
            dec_state = StPop;
            dec_list  = {instr[8], 7'b0, instr[7:0]};
        end
    end

    // PUSH drains from the highest register, POP from the lowest.
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (list_q[i]) hi_idx = 4'(i);
        end
        for (int i = 15; i >= 0; i--) begin
            if (list_q[i]) lo_idx = 4'(i);
        end
    end

    assign cur_idx   = (state_q == StPush) ? hi_idx : lo_idx;
    assign last_xfer = (list_q & ~(16'h0001 << cur_idx)) == 16'h0000;
    assign sp_out    = sp_q;
    assign illegal   = illegal_q;

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        op_d        = op_q;
        list_d      = list_q;
        sp_d        = sp_q;
        illegal_d   = 1'b0;
        instr_ready = 1'b0;
        op_sel      = OpNop;
        immed7      = '0;
        immed8      = '0;
        dp_in       = sp_q;
        rf_raddr    = '0;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        done        = 1'b0;

        unique case (state_q)
            StIdle: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    ir_d      = instr[10:0];
                    op_d      = dec_op;
                    list_d    = dec_list;
                    state_d   = dec_state;
                    illegal_d = (dec_state == StIdle);
                end
            end
            StExec: begin
                op_sel  = op_q;
                done    = 1'b1;
                state_d = StIdle;
                case (op_q)
                    OpAddsp, OpSubsp: begin
                        immed7 = ir_q[6:0];
                        sp_d   = dp_out;
                    end
                    OpAdds: begin
                        immed8   = ir_q[7:0];
                        rf_we    = 1'b1;
                        rf_waddr = {1'b0, ir_q[10:8]};
                        rf_wdata = dp_out;
                    end
                    OpMovsp: begin
                        rf_raddr = ir_q[6:3];
                        dp_in    = rf_rdata;
                        sp_d     = {dp_out[31:2], 2'b00};
                    end
                    default: ;
                endcase
            end
            StMem: begin
                op_sel   = op_q;
                immed8   = ir_q[7:0];
                mem_addr = dp_out;
                mem_req  = 1'b1;
                if (op_q == OpStrsp) begin
                    mem_we    = 1'b1;
                    rf_raddr  = {1'b0, ir_q[10:8]};
                    mem_wdata = rf_rdata;
                end
                if (mem_ack) begin
                    if (op_q == OpLdrsp) begin
                        rf_we    = 1'b1;
                        rf_waddr = {1'b0, ir_q[10:8]};
                        rf_wdata = mem_rdata;
                    end
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            StPush: begin
                op_sel    = OpPush;
                mem_addr  = dp_out;
                mem_we    = 1'b1;
                rf_raddr  = cur_idx;
                mem_wdata = rf_rdata;
                mem_req   = 1'b1;
                if (mem_ack) begin
                    sp_d            = dp_out;
                    list_d[cur_idx] = 1'b0;
                    if (last_xfer) begin
                        done    = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StPop: begin
                op_sel   = OpPop;
                mem_addr = sp_q;
                mem_req  = 1'b1;
                if (mem_ack) begin
                    rf_we           = 1'b1;
                    rf_waddr        = cur_idx;
                    rf_wdata        = mem_rdata;
                    sp_d            = dp_out;
                    list_d[cur_idx] = 1'b0;
                    if (last_xfer) begin
                        done    = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_st_stack_ctrl.sv
// Bench for st_stack_ctrl: models the stack datapath, register file and a
// wait-state memory, then runs a vector table plus multi-cycle sequences.
module tb_st_stack_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [7:0]  op_sel;
    logic [6:0]  immed7;
    logic [7:0]  immed8;
    logic [31:0] dp_in, dp_out, sp_out;
    logic [3:0]  rf_raddr, rf_waddr;
    logic [31:0] rf_rdata, rf_wdata;
    logic        rf_we;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        done, illegal;

    always #5 clk = ~clk;

    st_stack_ctrl #(.SP_RESET(32'h0000_1000)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .op_sel(op_sel), .immed7(immed7), .immed8(immed8),
        .dp_in(dp_in), .dp_out(dp_out), .sp_out(sp_out), .rf_raddr(rf_raddr),
        .rf_rdata(rf_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .done(done), .illegal(illegal)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Stack datapath model
    always_comb begin
        case (op_sel)
            8'h01:   dp_out = dp_in - 32'd4;
            8'h02:   dp_out = dp_in + 32'd4;
            8'h04:   dp_out = dp_in + {23'b0, immed7, 2'b00};
            8'h08:   dp_out = dp_in - {23'b0, immed7, 2'b00};
            8'h10:   dp_out = dp_in;
            8'h20, 8'h40, 8'h80: dp_out = dp_in + {22'b0, immed8, 2'b00};
            default: dp_out = dp_in;
        endcase
    end

    // Register file model with a bench-side preset port
    logic [31:0] rf [16];
    logic        set_en = 1'b0;
    logic [3:0]  set_addr = '0;
    logic [31:0] set_data = '0;
    logic [35:0] rflog[$];
    assign rf_rdata = rf[rf_raddr];
    always @(posedge clk) begin
        if (set_en) rf[set_addr] <= set_data;
        else if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
            rflog.push_back({rf_waddr, rf_wdata});
        end
    end

    task automatic set_reg(input logic [3:0] a, input logic [31:0] d);
        set_en = 1'b1; set_addr = a; set_data = d;
        @(negedge clk);
        set_en = 1'b0;
    endtask

    // Memory responder: acks after mem_wait idle cycles, checks request hold
    logic [31:0] mem [logic [31:0]];
    logic [31:0] rlog[$];
    logic [63:0] mwlog[$];
    int          mem_wait = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    initial begin
        int          wcnt;
        bit          in_req;
        logic [31:0] h_addr;
        logic        h_we;
        wcnt = 0; in_req = 0; h_addr = '0; h_we = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        mem[32'h1014] = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (mem_req) begin
                if (!in_req) begin
                    in_req = 1; h_addr = mem_addr; h_we = mem_we;
                end else begin
                    chk("hold_addr", mem_addr, h_addr);
                    chk("hold_we", {31'b0, mem_we}, {31'b0, h_we});
                end
                if (wcnt >= mem_wait) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        mem[mem_addr] = mem_wdata;
                        mwlog.push_back({mem_addr, mem_wdata});
                    end else begin
                        mem_rdata = mem_rd(mem_addr);
                        rlog.push_back(mem_addr);
                    end
                    in_req = 0; wcnt = 0;
                end else wcnt++;
            end else begin
                in_req = 0; wcnt = 0;
            end
        end
    end

    int n_done = 0, n_ill = 0, n_req = 0;
    always @(negedge clk) begin
        if (done) n_done++;
        if (illegal) n_ill++;
        if (mem_req) n_req++;
    end

    // Offer one instruction; returns cycles from accept edge to done/illegal.
    task automatic run_instr(input logic [15:0] ins, output int lat, output bit got_ill);
        int k;
        lat = -1; got_ill = 0; k = 0;
        while (!instr_ready && k < 100) begin @(negedge clk); k++; end
        instr = ins; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0; instr = '0;
        for (k = 1; k <= 300 && lat < 0; k++) begin
            if (done) lat = k;
            else if (illegal) begin lat = k; got_ill = 1; end
            if (lat < 0) @(negedge clk);
        end
        if (lat < 0) chk("timeout", 32'hFFFF_FFFF, 32'h0);
    endtask

    typedef struct {
        logic [15:0] ins;
        bit          exp_ill;
        int          exp_lat;
        logic [31:0] exp_sp;
        bit          chk_rf;
        logic [3:0]  rf_idx;
        logic [31:0] rf_val;
        bit          chk_mem;
        logic [31:0] maddr;
        logic [31:0] mval;
    } vec_t;

    vec_t vt[12];

    initial begin
        int lat;
        bit gi;
        int d0, r0;
        vt[0]  = '{16'hB083, 0, 1, 32'h0FF4, 0, 4'd0, 32'h0, 0, 32'h0, 32'h0};
        vt[1]  = '{16'hB003, 0, 1, 32'h1000, 0, 4'd0, 32'h0, 0, 32'h0, 32'h0};
        vt[2]  = '{16'hA801, 0, 1, 32'h1000, 1, 4'd0, 32'h1004, 0, 32'h0, 32'h0};
        vt[3]  = '{16'h9A05, 0, 2, 32'h1000, 1, 4'd2, 32'hDEAD_BEEF, 0, 32'h0, 32'h0};
        vt[4]  = '{16'h9302, 0, 2, 32'h1000, 0, 4'd0, 32'h0, 1, 32'h1008, 32'h33};
        vt[5]  = '{16'hB400, 1, 1, 32'h1000, 0, 4'd0, 32'h0, 0, 32'h0, 32'h0};
        vt[6]  = '{16'hDE00, 1, 1, 32'h1000, 0, 4'd0, 32'h0, 0, 32'h0, 32'h0};
        vt[7]  = '{16'hB0FF, 0, 1, 32'h0E04, 0, 4'd0, 32'h0, 0, 32'h0, 32'h0};
        vt[8]  = '{16'hB07F, 0, 1, 32'h1000, 0, 4'd0, 32'h0, 0, 32'h0, 32'h0};
        vt[9]  = '{16'h4685, 0, 1, 32'h1004, 0, 4'd0, 32'h0, 0, 32'h0, 32'h0};
        vt[10] = '{16'h46A5, 0, 1, 32'h1000, 0, 4'd0, 32'h0, 0, 32'h0, 32'h0};
        vt[11] = '{16'hBC00, 1, 1, 32'h1000, 0, 4'd0, 32'h0, 0, 32'h0, 32'h0};

        reset = 1'b1; instr_valid = 1'b0; instr = '0;
        repeat (3) @(negedge clk);
        chk("rst_sp", sp_out, 32'h1000);
        chk("rst_ready", {31'b0, instr_ready}, 32'h1);
        chk("rst_req", {31'b0, mem_req}, 32'h0);
        chk("rst_op", {24'b0, op_sel}, 32'h0);
        chk("rst_done_ill", {30'b0, done, illegal}, 32'h0);
        reset = 1'b0;
        set_reg(4'd3, 32'h33);
        set_reg(4'd4, 32'h1002);

        mem_wait = 1;
        for (int i = 0; i < 12; i++) begin
            r0 = n_req;
            run_instr(vt[i].ins, lat, gi);
            chk($sformatf("v%0d_lat", i), lat, vt[i].exp_lat);
            chk($sformatf("v%0d_ill", i), {31'b0, gi}, {31'b0, vt[i].exp_ill});
            if (!vt[i].exp_ill) chk($sformatf("v%0d_busy", i), {31'b0, instr_ready}, 32'h0);
            @(negedge clk);
            chk($sformatf("v%0d_ready", i), {31'b0, instr_ready}, 32'h1);
            chk($sformatf("v%0d_sp", i), sp_out, vt[i].exp_sp);
            if (vt[i].chk_rf) chk($sformatf("v%0d_rf", i), rf[vt[i].rf_idx], vt[i].rf_val);
            if (vt[i].chk_mem) chk($sformatf("v%0d_mem", i), mem_rd(vt[i].maddr), vt[i].mval);
            if (vt[i].exp_ill) chk($sformatf("v%0d_noreq", i), n_req - r0, 32'h0);
        end

        // PUSH {r1,r3,LR}, two wait cycles per word
        set_reg(4'd1, 32'h11); set_reg(4'd14, 32'hEE);
        mem_wait = 2; mwlog.delete(); d0 = n_done;
        run_instr(16'hB50A, lat, gi);
        chk("push_lat", lat, 9);
        @(negedge clk);
        chk("push_n", mwlog.size(), 3);
        if (mwlog.size() == 3) begin
            chk("push_w0", mwlog[0][63:32], 32'hFFC); chk("push_d0", mwlog[0][31:0], 32'hEE);
            chk("push_w1", mwlog[1][63:32], 32'hFF8); chk("push_d1", mwlog[1][31:0], 32'h33);
            chk("push_w2", mwlog[2][63:32], 32'hFF4); chk("push_d2", mwlog[2][31:0], 32'h11);
        end
        chk("push_sp", sp_out, 32'hFF4);
        chk("push_done", n_done - d0, 1);

        // POP {r1,r3,PC}
        set_reg(4'd1, 32'h0); set_reg(4'd3, 32'h0); set_reg(4'd15, 32'h0);
        mem_wait = 0; rlog.delete(); rflog.delete();
        run_instr(16'hBD0A, lat, gi);
        chk("pop_lat", lat, 3);
        @(negedge clk);
        chk("pop_n", rlog.size(), 3);
        if (rlog.size() == 3) begin
            chk("pop_a0", rlog[0], 32'hFF4); chk("pop_a1", rlog[1], 32'hFF8);
            chk("pop_a2", rlog[2], 32'hFFC);
        end
        chk("pop_wn", rflog.size(), 3);
        if (rflog.size() == 3) begin
            chk("pop_o0", {28'b0, rflog[0][35:32]}, 32'd1);
            chk("pop_o1", {28'b0, rflog[1][35:32]}, 32'd3);
            chk("pop_o2", {28'b0, rflog[2][35:32]}, 32'd15);
        end
        chk("pop_r1", rf[1], 32'h11); chk("pop_r3", rf[3], 32'h33);
        chk("pop_pc", rf[15], 32'hEE);
        chk("pop_sp", sp_out, 32'h1000);

        // MOV SP,r4 aligns; ADD r0,SP,#1
        set_reg(4'd4, 32'h2003);
        run_instr(16'h46A5, lat, gi);
        chk("mov_lat", lat, 1);
        @(negedge clk);
        chk("mov_sp", sp_out, 32'h2000);
        run_instr(16'hA801, lat, gi);
        @(negedge clk);
        chk("adds_r0", rf[0], 32'h2004);

        // SP wraps below zero
        set_reg(4'd5, 32'h0); set_reg(4'd0, 32'h77);
        run_instr(16'h46AD, lat, gi);
        @(negedge clk);
        chk("sp_zero", sp_out, 32'h0);
        mwlog.delete();
        run_instr(16'hB401, lat, gi);
        @(negedge clk);
        chk("wrap_n", mwlog.size(), 1);
        if (mwlog.size() == 1) chk("wrap_addr", mwlog[0][63:32], 32'hFFFF_FFFC);
        chk("wrap_sp", sp_out, 32'hFFFF_FFFC);

        // Reset while a PUSH word is outstanding
        mem_wait = 20; d0 = n_done;
        instr = 16'hB403; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0; instr = '0;
        for (int k = 0; k < 10 && !mem_req; k++) @(negedge clk);
        chk("mid_req", {31'b0, mem_req}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_req_drop", {31'b0, mem_req}, 32'h0);
        chk("mid_sp", sp_out, 32'h1000);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_no_done", n_done - d0, 0);
        chk("mid_idle", {31'b0, instr_ready}, 32'h1);
        run_instr(16'hB083, lat, gi);
        chk("post_lat", lat, 1);
        @(negedge clk);
        chk("post_sp", sp_out, 32'h0FF4);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
